// File: rtl/packs.sv
// rtl/packs.sv - shared types and defaults for the stopwatch control path
// Contents:
//   sw_state_t          - control FSM state encoding (IDLE/RUN/LAP/PAUSE)
//   DB_TICKS_DEFAULT    - default debounce strobe count
//   SYNC_STAGES_DEFAULT - default synchronizer depth
package packs;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } sw_state_t;

  localparam int DB_TICKS_DEFAULT    = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, strobe-sampled debouncer and press pulse
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   tick     in  one-cycle debounce sampling strobe
//   btn      in  raw asynchronous button, active-high
//   level    out debounced button level
//   press    out one-cycle pulse on a rising edge of the debounced level
module btn_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_TICKS    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [3:0] DB_LAST = 4'(DB_TICKS - 1);

  logic       btn_sync;
  logic [3:0] cnt;
  logic       differ;
  logic       accept;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn),
    .q    (btn_sync)
  );

  assign differ = btn_sync != level;
  // The DB_TICKS-th consecutive differing sample flips the level.
  assign accept = tick && differ && (cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      // Registered so the pulse lands in the cycle after the accepting strobe.
      press <= accept && !level;
      if (tick) begin
        if (!differ || accept) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
        if (accept) begin
          level <= !level;
        end
      end
    end
  end

endmodule

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer for one asynchronous input
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset (chain clears to 0)
//   d      in  asynchronous input
//   q      out synchronized level
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button-driven control FSM for the stopwatch datapath
// Ports:
//   sysclk    in  system clock
//   rst       in  asynchronous active-low reset
//   tick_db   in  debounce sampling strobe
//   tick_cnt  in  count strobe from the counter divider
//   btn_ss    in  raw start/stop button
//   btn_lap   in  raw lap/reset button
//   sw_dir    in  raw direction switch (1 = count down)
//   cnt_tick  out gated count strobe to the counter
//   cnt_clr   out one-cycle counter clear
//   dir       out direction, latched only while idle
//   lap_hold  out 1 while the display is frozen on a lap value
//   state     out current FSM state
module stopwatch_ctrl
  import packs::*;
#(
  parameter int DB_TICKS    = DB_TICKS_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic      sysclk,
  input  logic      rst,
  input  logic      tick_db,
  input  logic      tick_cnt,
  input  logic      btn_ss,
  input  logic      btn_lap,
  input  logic      sw_dir,
  output logic      cnt_tick,
  output logic      cnt_clr,
  output logic      dir,
  output logic      lap_hold,
  output sw_state_t state
);

  logic      ss_p;
  logic      lap_p;
  logic      ss_level;
  logic      lap_level;
  logic      dir_sync;
  sw_state_t state_nxt;
  logic      clr_req;

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_TICKS(DB_TICKS)) u_db_ss (
    .clk  (sysclk),
    .rst_n(rst),
    .tick (tick_db),
    .btn  (btn_ss),
    .level(ss_level),
    .press(ss_p)
  );

  btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_TICKS(DB_TICKS)) u_db_lap (
    .clk  (sysclk),
    .rst_n(rst),
    .tick (tick_db),
    .btn  (btn_lap),
    .level(lap_level),
    .press(lap_p)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync_dir (
    .clk  (sysclk),
    .rst_n(rst),
    .d    (sw_dir),
    .q    (dir_sync)
  );

  // Start/stop has priority: a lap press in the same cycle is dropped.
  always_comb begin
    state_nxt = state;
    clr_req   = 1'b0;
    if (ss_p) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        LAP:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end else if (lap_p) begin
      case (state)
        IDLE: begin
          state_nxt = IDLE;
          clr_req   = 1'b1;
        end
        RUN:     state_nxt = LAP;
        LAP:     state_nxt = RUN;
        PAUSE: begin
          state_nxt = IDLE;
          clr_req   = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt_clr  <= 1'b0;
      lap_hold <= 1'b0;
      dir      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_clr  <= clr_req;
      lap_hold <= (state_nxt == LAP);
      if (state == IDLE) begin
        dir <= dir_sync;
      end
    end
  end

  // Combinational from the registered state so a tick coinciding with the
  // press that leaves RUN still reaches the counter.
  assign cnt_tick = tick_cnt && ((state == RUN) || (state == LAP));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic       sysclk;
  logic       rst;
  logic       tick_db;
  logic       tick_cnt;
  logic       btn_ss;
  logic       btn_lap;
  logic       sw_dir;
  logic       cnt_tick;
  logic       cnt_clr;
  logic       dir;
  logic       lap_hold;
  logic [1:0] state;

  int tests;
  int fails;

  stopwatch_ctrl #(.DB_TICKS(4), .SYNC_STAGES(2)) dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .tick_db (tick_db),
    .tick_cnt(tick_cnt),
    .btn_ss  (btn_ss),
    .btn_lap (btn_lap),
    .sw_dir  (sw_dir),
    .cnt_tick(cnt_tick),
    .cnt_clr (cnt_clr),
    .dir     (dir),
    .lap_hold(lap_hold),
    .state   (state)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic db_strobe();
    tick_db = 1'b1;
    step();
    tick_db = 1'b0;
    step();
  endtask

  // Drive buttons, let the synchronizer settle, then give 4 strobes.
  // On return the FSM has already taken the resulting press.
  task automatic do_press(input logic ss, input logic lap);
    btn_ss  = ss;
    btn_lap = lap;
    repeat (3) step();
    repeat (4) db_strobe();
  endtask

  task automatic do_release();
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    repeat (3) step();
    repeat (5) db_strobe();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    tick_db  = 1'b0;
    tick_cnt = 1'b0;
    btn_ss   = 1'b0;
    btn_lap  = 1'b0;
    sw_dir   = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      btn_ss   = i[0];
      btn_lap  = ~i[0];
      sw_dir   = 1'b1;
      tick_db  = 1'b1;
      tick_cnt = 1'b1;
      step();
    end
    check("rst_state", {6'd0, state}, 8'h00);
    check("rst_cnt_tick", {7'd0, cnt_tick}, 8'h00);
    check("rst_cnt_clr", {7'd0, cnt_clr}, 8'h00);
    check("rst_dir", {7'd0, dir}, 8'h00);
    check("rst_lap_hold", {7'd0, lap_hold}, 8'h00);
    btn_ss   = 1'b0;
    btn_lap  = 1'b0;
    sw_dir   = 1'b0;
    tick_db  = 1'b0;
    tick_cnt = 1'b0;
    step();
    rst = 1'b1;
    repeat (6) db_strobe();
    check("post_rst_state", {6'd0, state}, 8'h00);
    check("post_rst_clr", {7'd0, cnt_clr}, 8'h00);

    // Glitch of 3 strobes must be rejected.
    btn_ss = 1'b1;
    repeat (3) step();
    repeat (3) db_strobe();
    btn_ss = 1'b0;
    repeat (3) step();
    repeat (6) db_strobe();
    check("glitch_state", {6'd0, state}, 8'h00);

    // Held for 6 strobes: one press into RUN.
    do_press(1'b1, 1'b0);
    check("ss_run_state", {6'd0, state}, 8'h01);
    repeat (2) db_strobe();
    check("ss_held_state", {6'd0, state}, 8'h01);
    tick_cnt = 1'b1;
    #1;
    check("run_tick_pass", {7'd0, cnt_tick}, 8'h01);
    tick_cnt = 1'b0;
    #1;
    check("run_tick_low", {7'd0, cnt_tick}, 8'h00);
    do_release();
    check("ss_release_state", {6'd0, state}, 8'h01);

    // Lap enter / exit.
    do_press(1'b0, 1'b1);
    check("lap_state", {6'd0, state}, 8'h02);
    check("lap_hold_on", {7'd0, lap_hold}, 8'h01);
    tick_cnt = 1'b1;
    #1;
    check("lap_tick_pass", {7'd0, cnt_tick}, 8'h01);
    tick_cnt = 1'b0;
    do_release();
    do_press(1'b0, 1'b1);
    check("lap_exit_state", {6'd0, state}, 8'h01);
    check("lap_hold_off", {7'd0, lap_hold}, 8'h00);
    do_release();

    // Pause, with a tick coinciding with the press pulse cycle.
    btn_ss = 1'b1;
    repeat (3) step();
    repeat (3) db_strobe();
    tick_db = 1'b1;
    step();
    tick_db  = 1'b0;
    tick_cnt = 1'b1;
    #1;
    check("edge_tick_pass", {7'd0, cnt_tick}, 8'h01);
    check("edge_state_run", {6'd0, state}, 8'h01);
    step();
    check("pause_state", {6'd0, state}, 8'h03);
    check("pause_tick_block", {7'd0, cnt_tick}, 8'h00);
    tick_cnt = 1'b0;
    do_release();
    for (int i = 0; i < 20; i++) begin
      tick_cnt = 1'b1;
      #1;
      check("pause_tick_loop", {7'd0, cnt_tick}, 8'h00);
      step();
      tick_cnt = 1'b0;
      step();
    end

    // PAUSE -> IDLE with a single clear.
    do_press(1'b0, 1'b1);
    check("clr_state_idle", {6'd0, state}, 8'h00);
    check("clr_pulse", {7'd0, cnt_clr}, 8'h01);
    step();
    check("clr_one_cycle", {7'd0, cnt_clr}, 8'h00);
    do_release();

    // IDLE lap press: clear while staying idle.
    do_press(1'b0, 1'b1);
    check("idle_clr_state", {6'd0, state}, 8'h00);
    check("idle_clr_pulse", {7'd0, cnt_clr}, 8'h01);
    step();
    check("idle_clr_end", {7'd0, cnt_clr}, 8'h00);
    do_release();

    // Direction latch in IDLE: visible after SYNC_STAGES+1 edges.
    check("dir_before", {7'd0, dir}, 8'h00);
    sw_dir = 1'b1;
    repeat (2) step();
    check("dir_sync_wait", {7'd0, dir}, 8'h00);
    step();
    check("dir_latched", {7'd0, dir}, 8'h01);

    // Simultaneous press: start/stop wins, no clear.
    do_press(1'b1, 1'b1);
    check("simul_state", {6'd0, state}, 8'h01);
    check("simul_no_clr", {7'd0, cnt_clr}, 8'h00);
    sw_dir = 1'b0;
    repeat (5) step();
    check("dir_held_run", {7'd0, dir}, 8'h01);
    do_release();

    // Into LAP, then asynchronous reset between clock edges.
    do_press(1'b0, 1'b1);
    check("pre_arst_state", {6'd0, state}, 8'h02);
    do_release();
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", {6'd0, state}, 8'h00);
    check("arst_lap_hold", {7'd0, lap_hold}, 8'h00);
    check("arst_cnt_clr", {7'd0, cnt_clr}, 8'h00);
    check("arst_dir", {7'd0, dir}, 8'h00);
    step();
    rst = 1'b1;
    repeat (3) db_strobe();
    check("arst_after_state", {6'd0, state}, 8'h00);
    check("arst_after_clr", {7'd0, cnt_clr}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven control FSM for the stopwatch datapath. Sits between the board push-buttons/switch and the `stopwatch` counter and digit selector. It performs three jobs:
- debounces start/stop and lap/reset buttons;
- gates the count tick into the counter and issues counter clears;
- freezes the displayed value during a lap and latches the count direction.

## Interface
Parameters:
- `DB_TICKS`, 4: consecutive equal `tick_db` samples required to accept a new debounced button level (2..15).
- `SYNC_STAGES`, 2: synchronizer flops per button input (≥2).

Ports:
- `sysclk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tick_db`  in  1  one-cycle sampling strobe for debounce (display-refresh tick).
- `tick_cnt`  in  1  one-cycle count strobe from the counter clock divider.
- `btn_ss`  in  1  raw start/stop button, asynchronous, active-high.
- `btn_lap`  in  1  raw lap/reset button, asynchronous, active-high.
- `sw_dir`  in  1  raw direction switch (1 = count down).
- `cnt_tick`  out  1  gated count strobe to `stopwatch.tick`.
- `cnt_clr`  out  1  one-cycle synchronous clear to the counter.
- `dir`  out  1  latched direction to `stopwatch.sign`.
- `lap_hold`  out  1  1 = selector shows frozen lap value.
- `state`  out  2  current FSM state (`sw_state_t`), for LEDs and debug.

## Operation
- **Button conditioning** (per button):
  - `SYNC_STAGES`-flop synchronizer.
  - Debouncer samples the synchronized level only on `tick_db`. A stable-count register increments while the sample differs from the debounced level, and resets to 0 when the sample matches.
  - When the count reaches `DB_TICKS`, the debounced level toggles and the count clears.
  - A rising edge of the debounced level produces a one-cycle press pulse (`ss_p`, `lap_p`).
- **FSM states:** IDLE=2'b00, RUN=2'b01, LAP=2'b10, PAUSE=2'b11.
  - IDLE:
    - `ss_p` → RUN.
    - `lap_p` → stays in IDLE and pulses `cnt_clr`.
  - RUN:
    - `ss_p` → PAUSE.
    - `lap_p` → LAP.
  - LAP:
    - `lap_p` → RUN (display resumes live value).
    - `ss_p` → PAUSE (hold released).
  - PAUSE:
    - `ss_p` → RUN.
    - `lap_p` → IDLE and pulses `cnt_clr`.
- **Simultaneous presses:** when `ss_p` and `lap_p` occur in the same cycle, `ss_p` wins and `lap_p` is discarded.
- **Outputs:**
  - `cnt_tick = tick_cnt & (state==RUN | state==LAP)`. This is combinational from the registered state, with no added latency.
  - `lap_hold` is registered and equals 1 exactly while state==LAP.
  - `cnt_clr` is registered and high for exactly one cycle, in the cycle after the qualifying `lap_p`.
  - `dir` is registered from the synchronized `sw_dir` only while state==IDLE, and held constant in all other states.
- `sw_dir` uses the same synchronizer but is not debounced.

## Timing
- **Reset values:** state=IDLE, `cnt_tick`=0, `cnt_clr`=0, `dir`=0, `lap_hold`=0; debouncer levels, counts and synchronizers all 0.
- **Reset mid-operation:** asserting `rst` at any point returns to IDLE immediately and asynchronously. The counter is not cleared by this block; `cnt_clr` stays 0.
- **Press latency:** after a raw edge, `SYNC_STAGES` cycles pass, then `DB_TICKS` `tick_db` strobes are needed to accept the level. The press pulse occurs in the cycle after the accepting strobe, and the state changes on the following edge.
- **Tick at a transition:** a `tick_cnt` in the same cycle as the `ss_p` that leaves RUN is passed through, because state is still RUN.
- **Clear pulse:** `cnt_clr` is asserted in the same cycle that the state becomes IDLE, or in the cycle after the IDLE→IDLE clear.
- **Glitch rejection:** a bounce shorter than `DB_TICKS` `tick_db` periods produces no press.
- **Held button:** holding a button gives exactly one press; releasing it gives none.

## Structure
- Shared package `packs` adds:
  - `typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_t` with the encodings above.
  - `localparam DB_TICKS_DEFAULT = 4`.
- Sub-module `btn_debounce`: synchronizer, debounce counter and rising-edge pulse. It is instantiated twice, for `btn_ss` and `btn_lap`.
- `stopwatch_ctrl` contains the FSM, the direction latch and output registers.
- In `top`, `cnt_tick` replaces the direct `tick_contador` connection into `stopwatch`.
- `lap_hold` gates a digit-capture register in front of the selector.

## Test plan
- **Reset:** hold `rst`=0 with buttons toggling → all outputs 0 and `state`=00; release → IDLE, no press pulses.
- **Debounce:** `btn_ss` high for 3 `tick_db` strobes then low (DB_TICKS=4) → no transition. Then `btn_ss` held for 6 strobes → exactly one `ss_p`, `state`=01, and `cnt_tick` mirrors `tick_cnt`.
- **Lap sequence:** RUN, press lap → `state`=10, `lap_hold`=1 and `cnt_tick` still passes. Press lap → `state`=01, `lap_hold`=0.
- **Pause/reset:** RUN, press ss → `state`=11 and `cnt_tick`=0 for 20 `tick_cnt` strobes. Press lap → `state`=00 and a single-cycle `cnt_clr`=1.
- **Simultaneous and direction:** with `sw_dir`=1 in IDLE → `dir`=1 after `SYNC_STAGES`+1 cycles. Press ss and lap in the same cycle → RUN with no clear. Toggle `sw_dir`=0 while in RUN → `dir` stays 1.
- **Async reset mid-operation:** while in LAP, assert `rst` asynchronously → `lap_hold` and `state` go to 0 without a clock edge, and `cnt_clr` stays 0.
